peripheral_reg_responder: RTL and testbench
===========================================

# peripheral_reg_responder

AXI4-Lite responder (slave) holding a bank of memory-mapped 32-bit registers, placed at the far end of the core's peripheral bus when `PERIPHERAL_BUS_TYPE` is `AXI_BUS`. It accepts the core's single-beat read and write transactions. It decodes them against a configured `memory_config_t` range, updates or returns register contents, and exposes the register values to surrounding fabric. It is the target-side counterpart that lets the core's peripheral-bus path be exercised end to end.

## Interface
- `ADDR_RANGE`, default `'{L: 32'h60000000, H: 32'h6FFFFFFF}`: inclusive decode window (`memory_config_t`), aligned to its size.
- `NUM_REGS`, default 8: register count; power of 2, range 2–64.
- `RESET_VALUE`, default `32'h0`: reset value of every register.

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `awvalid` in 1, `awready` out 1, `awaddr` in 32: write address channel.
- `wvalid` in 1, `wready` out 1, `wdata` in 32, `wstrb` in 4: write data channel.
- `bvalid` out 1, `bready` in 1, `bresp` out 2: write response channel.
- `arvalid` in 1, `arready` out 1, `araddr` in 32: read address channel.
- `rvalid` out 1, `rready` in 1, `rdata` out 32, `rresp` out 2: read data channel.
- `regs_o` out `NUM_REGS*32`: current register contents; register i is at bits `[32*i+:32]`.
- `reg_written_o` out `NUM_REGS`: one-cycle pulse, one bit per register that was committed.

## Operation
- **Decode.** `offset = addr - ADDR_RANGE.L`.
  - If `addr` is outside `[L,H]`: response DECERR.
  - If `offset >= NUM_REGS*4`: response SLVERR.
  - Otherwise: response OKAY, and `index = offset[2 +: $clog2(NUM_REGS)]`.
  - `addr[1:0]` is ignored.
- **Write path.**
  - AW and W are captured independently into holding registers, flagged `aw_held` and `w_held`.
  - `awready = !aw_held && !bvalid`; `wready = !w_held && !bvalid`.
  - Commit happens when both are held, or both arrive in the same cycle, or one arrives while the other is already held.
  - On commit:
    - If OKAY, bytes with `wstrb` set are written to the register; otherwise no register changes.
    - `bvalid` is set with the decoded `bresp`.
    - Both held flags are cleared.
    - `reg_written_o[index]` pulses, only on OKAY with a nonzero `wstrb`.
- **Write FSM states.** `WR_COLLECT` transitions to `WR_RESP` on commit. `WR_RESP` transitions back to `WR_COLLECT` on `bvalid && bready`.
- **Read FSM states.** `RD_IDLE` (`arready=1`) transitions to `RD_RESP` on an `arvalid` handshake. `RD_RESP` (`rvalid=1`, `arready=0`) transitions back to `RD_IDLE` on `rready`.
- **Read data.** `rdata` is 0 for SLVERR and DECERR.
- **Independence.** Reads and writes proceed independently; at most one write and one read are outstanding.
- **Same-register collision.** If an AR handshake and a write commit to the same register occur in the same cycle, `rdata` returns the pre-write value.

## Timing
- **Reset values.** All outputs are 0 on reset, except `awready=1`, `wready=1`, `arready=1`, and `regs_o = {NUM_REGS{RESET_VALUE}}`. The held flags clear; both FSMs go to their idle states.
- **Write latency.** Register update, `bvalid` and `reg_written_o` all take effect at the clock edge ending the commit cycle.
  - AW and W in the same cycle: `bvalid` is asserted on the next cycle.
- **Read latency.** `rvalid` and `rdata` are registered and appear one cycle after the AR handshake.
- **Response stability.**
  - `bvalid`/`bresp` remain stable until `bready`.
  - `rvalid`/`rdata`/`rresp` remain stable until `rready`.
  - No ready signal depends combinationally on the matching `valid` input.
- **Throughput.**
  - Write: one write per 2 cycles minimum, because ready drops while `bvalid` is asserted.
  - Read: one read per 2 cycles.
- **Reset mid-transaction.** `rst` overrides everything. Pending held AW/W and outstanding B/R responses are discarded. `valid` outputs are low in the cycle after `rst`.

## Structure
- Add to the shared config package:
  - `axi_resp_t` enum: `OKAY=2'b00`, `SLVERR=2'b10`, `DECERR=2'b11`.
  - Function `addr_in_range(memory_config_t, addr)`.
- The write and read FSM enums stay local to the module.
- No sub-module. Byte-strobe merge and decode are inline functions.

## Test plan
- **Write then read.** AW+W at `0x60000004` with data `0xDEADBEEF`, `wstrb=4'hF` → `bvalid` the next cycle with `bresp=OKAY`, `reg_written_o=8'h02`, `regs_o[63:32]=0xDEADBEEF`. Then AR to the same address → `rvalid` one cycle later with `rdata=0xDEADBEEF`.
- **Channel skew.** AW at `0x60000008` in cycle 0, W with `0x12345678` in cycle 3 → `awready` low during cycles 1–3, commit in cycle 3, `bvalid` in cycle 4. Repeat with W leading AW by 2 cycles → same result.
- **Partial strobe and backpressure.** Reg0=`0xFFFFFFFF`; write `0x000000AA` with `wstrb=4'b0001`, `bready` held low for 5 cycles → reg0=`0xFFFFFFAA`. `bvalid` is held stable; `awready=wready=0` until `bready`.
- **Errors.** Write to `0x60000100` → SLVERR, no register change, no `reg_written_o` pulse. Read from `0x70000000` → DECERR with `rdata=0`.
- **Collision.** Reg2=`0x1`; write `0x2` commits in the same cycle as an AR to reg2 → `rdata=0x1`; a subsequent read returns `0x2`.
- **Reset mid-transaction.** AW held without W, plus an outstanding `rvalid`; assert `rst` for 1 cycle → next cycle `rvalid=0`, `bvalid=0`, `awready=1`, all registers equal `RESET_VALUE`. A late W alone does not commit.

Source files
------------

// File: rtl/peripheral_reg_responder_pkg.sv
// Shared configuration types for the peripheral bus responder: decode window,
// AXI response codes and the range-check helper.
package peripheral_reg_responder_pkg;

    typedef struct packed {
        logic [31:0] L;
        logic [31:0] H;
    } memory_config_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

    function automatic logic addr_in_range(input memory_config_t cfg, input logic [31:0] addr);
        return (addr >= cfg.L) && (addr <= cfg.H);
    endfunction

endpackage

// File: rtl/peripheral_reg_responder.sv
// AXI4-Lite register bank responder: single-beat reads and writes decoded
// against ADDR_RANGE, with register contents and commit pulses exposed.
module peripheral_reg_responder
    import peripheral_reg_responder_pkg::*;
#(
    parameter memory_config_t ADDR_RANGE = '{L: 32'h60000000, H: 32'h6FFFFFFF},
    parameter int             NUM_REGS    = 8,
    parameter logic [31:0]    RESET_VALUE = 32'h0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [31:0]            awaddr,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [31:0]            wdata,
    input  logic [3:0]             wstrb,
    output logic                   bvalid,
    input  logic                   bready,
    output logic [1:0]             bresp,
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [31:0]            araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [31:0]            rdata,
    output logic [1:0]             rresp,
    output logic [NUM_REGS*32-1:0] regs_o,
    output logic [NUM_REGS-1:0]    reg_written_o,
    output logic [0:0]             o_wr_state,
    output logic [0:0]             o_rd_state
);

    // Handshake rule on every channel: a beat transfers on the rising edge where
    // valid && ready are both high; a response holds valid and payload until then.

    localparam int          IDX_W     = $clog2(NUM_REGS);
    localparam logic [31:0] REG_BYTES = 32'(NUM_REGS * 4);

    localparam logic [0:0] WR_COLLECT = 1'b0;
    localparam logic [0:0] WR_RESP    = 1'b1;
    localparam logic [0:0] RD_IDLE    = 1'b0;
    localparam logic [0:0] RD_RESP    = 1'b1;

    function automatic axi_resp_t decode(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - ADDR_RANGE.L;
        if (!addr_in_range(ADDR_RANGE, addr)) return DECERR;
        else if (off >= REG_BYTES)            return SLVERR;
        else                                  return OKAY;
    endfunction

    function automatic logic [IDX_W-1:0] addr_index(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - ADDR_RANGE.L;
        return off[2 +: IDX_W];
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

    logic [0:0]          r_wr_state;
    logic [0:0]          r_rd_state;
    logic                r_aw_held;
    logic [31:0]         r_awaddr;
    logic                r_w_held;
    logic [31:0]         r_wdata;
    logic [3:0]          r_wstrb;
    axi_resp_t           r_bresp;
    axi_resp_t           r_rresp;
    logic [31:0]         r_rdata;
    logic [31:0]         r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_reg_written;

    logic                w_aw_fire;
    logic                w_w_fire;
    logic                w_ar_fire;
    logic                w_commit;
    logic [31:0]         w_wr_addr;
    logic [31:0]         w_wr_data;
    logic [3:0]          w_wr_strb;
    axi_resp_t           w_wr_resp;
    logic [IDX_W-1:0]    w_wr_idx;
    axi_resp_t           w_rd_resp;
    logic [IDX_W-1:0]    w_rd_idx;

    assign awready = !r_aw_held && (r_wr_state == WR_COLLECT);
    assign wready  = !r_w_held  && (r_wr_state == WR_COLLECT);
    assign arready = (r_rd_state == RD_IDLE);
    assign bvalid  = (r_wr_state == WR_RESP);
    assign rvalid  = (r_rd_state == RD_RESP);

    assign w_aw_fire = awvalid && awready;
    assign w_w_fire  = wvalid && wready;
    assign w_ar_fire = arvalid && arready;
    // A held beat and a live beat may complete the pair in the same cycle.
    assign w_commit  = (r_aw_held || w_aw_fire) && (r_w_held || w_w_fire);

    assign w_wr_addr = r_aw_held ? r_awaddr : awaddr;
    assign w_wr_data = r_w_held  ? r_wdata  : wdata;
    assign w_wr_strb = r_w_held  ? r_wstrb  : wstrb;
    assign w_wr_resp = decode(w_wr_addr);
    assign w_wr_idx  = addr_index(w_wr_addr);
    assign w_rd_resp = decode(araddr);
    assign w_rd_idx  = addr_index(araddr);

    assign bresp         = r_bresp;
    assign rresp         = r_rresp;
    assign rdata         = r_rdata;
    assign reg_written_o = r_reg_written;
    assign o_wr_state    = r_wr_state;
    assign o_rd_state    = r_rd_state;

    always_comb begin
        regs_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_o[32*i +: 32] = r_regs[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_state    <= WR_COLLECT;
            r_aw_held     <= 1'b0;
            r_awaddr      <= '0;
            r_w_held      <= 1'b0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_bresp       <= OKAY;
            r_reg_written <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= RESET_VALUE;
            end
        end else begin
            r_reg_written <= '0;
            case (r_wr_state)
                WR_COLLECT: begin
                    if (w_commit) begin
                        r_wr_state <= WR_RESP;
                        r_bresp    <= w_wr_resp;
                        r_aw_held  <= 1'b0;
                        r_w_held   <= 1'b0;
                        if (w_wr_resp == OKAY) begin
                            r_regs[w_wr_idx] <= merge(r_regs[w_wr_idx], w_wr_data, w_wr_strb);
                            r_reg_written[w_wr_idx] <= (w_wr_strb != 4'h0);
                        end
                    end else begin
                        if (w_aw_fire) begin
                            r_aw_held <= 1'b1;
                            r_awaddr  <= awaddr;
                        end
                        if (w_w_fire) begin
                            r_w_held <= 1'b1;
                            r_wdata  <= wdata;
                            r_wstrb  <= wstrb;
                        end
                    end
                end
                default: begin
                    if (bready) r_wr_state <= WR_COLLECT;
                end
            endcase
        end
    end

    // Read samples r_regs before this edge's write lands, so a colliding
    // read returns the pre-write value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_state <= RD_IDLE;
            r_rresp    <= OKAY;
            r_rdata    <= '0;
        end else begin
            case (r_rd_state)
                RD_IDLE: begin
                    if (w_ar_fire) begin
                        r_rd_state <= RD_RESP;
                        r_rresp    <= w_rd_resp;
                        r_rdata    <= (w_rd_resp == OKAY) ? r_regs[w_rd_idx] : 32'h0;
                    end
                end
                default: begin
                    if (rready) r_rd_state <= RD_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_reg_responder.sv
// Directed bench for peripheral_reg_responder: stimulus pushes expected B/R
// responses, a negedge monitor pops them on each handshake.
module tb_peripheral_reg_responder;

    logic         clk;
    logic         rst;
    logic         awvalid, awready;
    logic [31:0]  awaddr;
    logic         wvalid, wready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         bvalid, bready;
    logic [1:0]   bresp;
    logic         arvalid, arready;
    logic [31:0]  araddr;
    logic         rvalid, rready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic [255:0] regs_o;
    logic [7:0]   reg_written_o;
    logic [0:0]   o_wr_state, o_rd_state;

    logic [1:0]   exp_b_q[$];
    logic [33:0]  exp_r_q[$];
    int           n_cmp = 0;
    int           n_fail = 0;
    logic [255:0] snap;

    peripheral_reg_responder dut (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .regs_o(regs_o), .reg_written_o(reg_written_o),
        .o_wr_state(o_wr_state), .o_rd_state(o_rd_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        awvalid = 1'b0; awaddr = '0;
        wvalid  = 1'b0; wdata  = '0; wstrb = '0;
        arvalid = 1'b0; araddr = '0;
    endtask

    // drive AW and W together for one cycle (both readies known high)
    task automatic write_pair(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                              input logic [1:0] exp_resp);
        exp_b_q.push_back(exp_resp);
        awvalid = 1'b1; awaddr = a;
        wvalid  = 1'b1; wdata  = d; wstrb = s;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic read_one(input logic [31:0] a, input logic [33:0] exp_rsp);
        exp_r_q.push_back(exp_rsp);
        arvalid = 1'b1; araddr = a;
        step();
        arvalid = 1'b0;
    endtask

    // scoreboard monitor: handshake completes at the following posedge
    always begin
        @(negedge clk);
        if (!rst && bvalid && bready) begin
            if (exp_b_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL b_unexpected: got bresp %0h expected no response", bresp);
            end else begin
                check("bresp", {254'b0, bresp}, {254'b0, exp_b_q.pop_front()});
            end
        end
        if (!rst && rvalid && rready) begin
            if (exp_r_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL r_unexpected: got rresp %0h rdata %0h expected no response", rresp, rdata);
            end else begin
                check("rresp_rdata", {222'b0, rresp, rdata}, {222'b0, exp_r_q.pop_front()});
            end
        end
    end

    initial begin
        idle_inputs();
        bready = 1'b1; rready = 1'b1;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;

        // reset state
        check("rst_awready", awready, 1);
        check("rst_wready", wready, 1);
        check("rst_arready", arready, 1);
        check("rst_valids", {bvalid, rvalid}, 0);
        check("rst_regs", regs_o, 0);
        check("rst_written", reg_written_o, 0);

        // write then read
        write_pair(32'h60000004, 32'hDEADBEEF, 4'hF, 2'b00);
        check("t1_bvalid", bvalid, 1);
        check("t1_written", reg_written_o, 8'h02);
        check("t1_reg1", regs_o[63:32], 32'hDEADBEEF);
        check("t1_awready_busy", {awready, wready}, 0);
        step();
        check("t1_bvalid_done", bvalid, 0);
        check("t1_written_clear", reg_written_o, 0);
        read_one(32'h60000004, {2'b00, 32'hDEADBEEF});
        check("t1_rvalid", rvalid, 1);
        check("t1_arready_busy", arready, 0);
        step();
        check("t1_rvalid_done", rvalid, 0);

        // AW leads W by 3 cycles
        exp_b_q.push_back(2'b00);
        awvalid = 1'b1; awaddr = 32'h60000008;
        step();
        awvalid = 1'b0;
        check("skew_aw_c1", {awready, wready, bvalid}, 3'b010);
        step();
        check("skew_aw_c2", {awready, bvalid}, 2'b00);
        step();
        check("skew_aw_c3", {awready, bvalid}, 2'b00);
        wvalid = 1'b1; wdata = 32'h12345678; wstrb = 4'hF;
        step();
        wvalid = 1'b0;
        check("skew_aw_bvalid", bvalid, 1);
        check("skew_aw_reg2", regs_o[95:64], 32'h12345678);
        step();

        // W leads AW by 2 cycles
        exp_b_q.push_back(2'b00);
        wvalid = 1'b1; wdata = 32'hCAFEF00D; wstrb = 4'hF;
        step();
        wvalid = 1'b0;
        check("skew_w_c1", {awready, wready, bvalid}, 3'b100);
        step();
        awvalid = 1'b1; awaddr = 32'h6000000C;
        step();
        awvalid = 1'b0;
        check("skew_w_bvalid", bvalid, 1);
        check("skew_w_reg3", regs_o[127:96], 32'hCAFEF00D);
        step();

        // partial strobe with B backpressure
        write_pair(32'h60000000, 32'hFFFFFFFF, 4'hF, 2'b00);
        step();
        bready = 1'b0;
        write_pair(32'h60000000, 32'h000000AA, 4'b0001, 2'b00);
        check("strb_written", reg_written_o, 8'h01);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", {bvalid, bresp, awready, wready}, 5'b10000);
            step();
        end
        check("strb_reg0", regs_o[31:0], 32'hFFFFFFAA);
        bready = 1'b1;
        step();
        check("bp_release", {bvalid, awready, wready}, 3'b011);

        // error responses
        snap = regs_o;
        write_pair(32'h60000100, 32'h11111111, 4'hF, 2'b10);
        check("slverr_written", reg_written_o, 0);
        check("slverr_regs", regs_o, snap);
        step();
        read_one(32'h70000000, {2'b11, 32'h0});
        step();
        read_one(32'h60000020, {2'b10, 32'h0});
        step();
        read_one(32'h6000000F, {2'b00, 32'hCAFEF00D});
        step();
        write_pair(32'h5FFFFFFC, 32'h22222222, 4'hF, 2'b11);
        check("decerr_regs", regs_o, snap);
        step();

        // zero strobe: OKAY but no pulse
        write_pair(32'h6000001C, 32'h33333333, 4'h0, 2'b00);
        check("zero_strb_written", reg_written_o, 0);
        step();

        // same-register collision returns pre-write value
        write_pair(32'h60000008, 32'h00000001, 4'hF, 2'b00);
        step();
        exp_b_q.push_back(2'b00);
        exp_r_q.push_back({2'b00, 32'h00000001});
        awvalid = 1'b1; awaddr = 32'h60000008;
        wvalid  = 1'b1; wdata  = 32'h00000002; wstrb = 4'hF;
        arvalid = 1'b1; araddr = 32'h60000008;
        step();
        idle_inputs();
        check("coll_reg2", regs_o[95:64], 32'h2);
        step();
        read_one(32'h60000008, {2'b00, 32'h00000002});
        step();

        // reset with AW held and R outstanding
        awvalid = 1'b1; awaddr = 32'h60000010;
        step();
        awvalid = 1'b0;
        rready = 1'b0;
        arvalid = 1'b1; araddr = 32'h60000000;
        step();
        arvalid = 1'b0;
        check("mid_rvalid_pending", rvalid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        rready = 1'b1;
        check("mid_valids", {rvalid, bvalid}, 0);
        check("mid_readies", {awready, wready, arready}, 3'b111);
        check("mid_regs", regs_o, 0);
        wvalid = 1'b1; wdata = 32'h55555555; wstrb = 4'hF;
        step();
        wvalid = 1'b0;
        check("late_w_nocommit", {bvalid, reg_written_o}, 0);
        check("late_w_held", {awready, wready}, 2'b10);
        step();
        check("late_w_reg4", regs_o[159:128], 0);

        // drain: every expected response must have been seen
        step(); step();
        check("b_queue_empty", exp_b_q.size(), 0);
        check("r_queue_empty", exp_r_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
